serial_adder: RTL
=================

Name: serial_adder

Overview:
Bit-serial N-bit adder built around a single full-adder cell and a carry flip-flop. It is the sequential stage that feeds operand bits, LSB first, into the one-bit full adder and collects its sum/carry outputs.
- Loads two WIDTH-bit operands and a carry-in on a start handshake.
- Performs one bit per clock.
- Presents the registered WIDTH-bit sum and carry-out with a one-cycle done pulse.

Parameters:
- WIDTH, 4, operand/sum width in bits; legal range >= 1.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request to begin an addition; sampled on rising edge of clk.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- cin  input  1  carry-in for bit 0; captured when start is accepted.
- busy  output  1  high while the state is RUN.
- done  output  1  one-cycle pulse; sum/cout are valid from this cycle on.
- sum  output  WIDTH  registered result, bits [WIDTH-1:0] of a+b+cin.
- cout  output  1  registered carry out of bit WIDTH-1.

Behaviour:
- Reset: while rst_n=0 at a rising edge, state=IDLE.
  - Internal shift registers, carry flip-flop and bit counter clear to 0.
  - Outputs: sum=0, cout=0, busy=0, done=0.
- Reset during RUN aborts the operation. No done pulse is produced for the aborted operation.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with start=1:
  - capture a, b into operand shift registers;
  - load the carry flip-flop with cin;
  - clear the bit counter;
  - go to RUN.
- IDLE with start=0: stay in IDLE.
- RUN: each edge performs one bit, index i = counter value:
  - s = a_sr[0]^b_sr[0]^c;
  - c' = majority(a_sr[0], b_sr[0], c);
  - s shifts into the MSB of the result shift register;
  - both operand registers shift right by 1;
  - carry flip-flop <= c';
  - counter increments.
- RUN exit: on the edge where the counter equals WIDTH-1 (last bit):
  - sum <= completed result, including that bit;
  - cout <= c' of that bit;
  - state -> DONE.
- start is ignored during RUN; the operands in flight are unaffected.
- DONE: done=1 for exactly this one cycle.
  - Next edge with start=1: accept new operands (same actions as IDLE) and go to RUN. Back-to-back operation, no idle gap.
  - Next edge with start=0: go to IDLE.
- Latency: start accepted at edge E0; last bit processed at edge E_WIDTH; done high in the cycle following E_WIDTH.
  - busy is high from after E0 through E_WIDTH.
  - Throughput: one result per WIDTH+1 cycles.
- sum/cout hold their values from DONE until the next DONE or reset. They never show partial results.
- WIDTH=1: a single RUN cycle. Results must equal the one-bit full-adder truth table.
- Counter width: $clog2(WIDTH+1) bits. Counter wrap is never reached because exit occurs at WIDTH-1.
- Arithmetic is unsigned modulo 2^WIDTH; cout carries the overflow.

Optional Feature:
Macro: SERIAL_ADDER_SUB_EN
- Defined:
  - Adds input port sub (1 bit), captured with the operands when start is accepted.
  - sub=1: every b bit is inverted before entering the adder, and the initial carry is forced to 1 (cin ignored). This gives sum = a - b mod 2^WIDTH and cout = 1 when there is no borrow (a >= b).
  - sub=0: identical to plain addition.
- Not defined: no sub port; addition only; RTL contains no inversion logic.

Test Plan:
- rst_n=0 for 2 edges after random activity -> sum=0, cout=0, busy=0, done=0, state IDLE; start low afterwards -> outputs unchanged.
- WIDTH=4: a=4'b0011, b=4'b0101, cin=0, start pulse at E0 -> busy high for 4 cycles; done pulse in the cycle after E4; sum=4'b1000, cout=0.
- WIDTH=4: a=4'hF, b=4'h1, cin=1 -> sum=4'h1, cout=1. Immediately restart from DONE with a=4'h7, b=4'h8, cin=0 -> no idle cycle; next result sum=4'hF, cout=0.
- WIDTH=4: start held high through RUN with changing a/b -> result reflects only the first captured operands; no extra done pulse.
- WIDTH=4: rst_n=0 at the edge processing bit 2 -> no done; outputs 0. A following start with a=2, b=2, cin=0 -> sum=4'h4, cout=0.
- WIDTH=1: all 8 (a,b,cin) combinations -> sum/cout match the full-adder truth table. With SERIAL_ADDER_SUB_EN, WIDTH=4:
  - a=5, b=3, sub=1 -> sum=2, cout=1;
  - a=3, b=5, sub=1 -> sum=4'hE, cout=0.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Optional subtract mode (input sub) is compiled in with `define SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned     CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] w_b_load;
  logic             w_cin_load;

  // The single full-adder cell operating on the current LSBs.
  assign w_s = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
  assign w_c = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_carry) | (r_b_sr[0] & r_carry);

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert B once at capture and force the carry-in.
  assign w_b_load   = sub ? ~b : b;
  assign w_cin_load = sub | cin;
`else
  assign w_b_load   = b;
  assign w_cin_load = cin;
`endif

  // Result shifter keeps only the WIDTH-1 bits already produced; the current bit is w_s.
  generate
    if (WIDTH > 1) begin : g_res
      logic [WIDTH-2:0] r_res_sr;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_res_sr <= '0;
        end else if (r_state == S_RUN) begin
          r_res_sr <= w_res_next[WIDTH-1:1];
        end
      end

      assign w_res_next = {w_s, r_res_sr};
    end else begin : g_res1
      assign w_res_next = w_s;
    end
  endgenerate

  // Control FSM, operand shifters, carry flop, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= w_b_load;
            r_carry <= w_cin_load;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          r_carry <= w_c;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_BIT) begin
            sum     <= w_res_next;
            cout    <= w_c;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
